clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//   N-channel integer clock divider generalising the single-ratio Tx/Rx dividers. Each channel divides
//   i_ref_clk by its own runtime ratio (even or odd), with a registered divided clock and a one-cycle tick.
//   Ratio and enable changes take effect only at period boundaries, so no runt pulses occur.
//   Sits beside the UART Tx/Rx clocking path; ratios come from the register file (one DIV_W slice per channel).
// PARAMETERS
//   N_CH    2  number of independent divider channels
//   DIV_W   8  ratio width per channel (matches DIV_RATIO_W)
// PORTS
//   i_ref_clk  in   1           reference clock; all state on rising edge
//   i_rst_n    in   1           synchronous active-low reset
//   i_en       in   N_CH        per-channel enable
//   i_ratio    in   N_CH*DIV_W  per-channel ratio; channel k = i_ratio[k*DIV_W +: DIV_W]
//   o_div_clk  out  N_CH        divided clock per channel
//   o_tick     out  N_CH        1-cycle pulse on each divided-clock rising edge
//   o_busy     out  N_CH        channel is DIVIDING or BYPASS
// BEHAVIOUR
//   Reset (i_rst_n=0 at an edge): every channel IDLE; cnt=0, r_act=0, div_reg=0, o_tick=0, o_busy=0.
//   Per channel k: state {IDLE, DIVIDING, BYPASS}; cnt and r_act are DIV_W bits.
//   Phase lengths: H = (r_act>>1) + r_act[0] cycles high, L = r_act>>1 cycles low (odd: high one longer).
//   IDLE:  i_en=0 -> stay, outputs 0.
//          i_en=1, i_ratio>=2 -> DIVIDING; r_act=i_ratio, cnt=0, div_reg=1, o_tick=1.
//          i_en=1, i_ratio<2  -> BYPASS.
//   DIVIDING, each edge:
//     cnt<r_act-1: cnt++, div_reg=(cnt+1 < H), o_tick=0.
//     cnt==r_act-1 (boundary): resample i_en/i_ratio:
//       i_en=0 -> IDLE, div_reg=0, o_tick=0.
//       i_ratio>=2 -> cnt=0, r_act=i_ratio, div_reg=1, o_tick=1.
//       i_ratio<2  -> BYPASS.
//   BYPASS: o_div_clk = i_ref_clk (combinational mux, the only non-registered path); o_tick=1 every cycle.
//     Each edge: i_en=0 -> IDLE; i_ratio>=2 -> DIVIDING, loads as from IDLE; else stay.
//   o_busy=1 in DIVIDING/BYPASS. o_div_clk=div_reg outside BYPASS.
//   Latency: first divided-clock rising edge one edge after i_en is sampled high in IDLE.
//   Mid-period changes of i_ratio/i_en are ignored until the boundary. i_en is checked only at the boundary, so
//     a period always completes. Ratio 255 (max): H=128, L=127. No wrap: cnt never exceeds r_act-1.
//   Reset mid-period returns to IDLE on that edge, regardless of state; channels are fully independent.
// TESTING
//   Ratio 4, en=1 from IDLE -> o_div_clk 1,1,0,0 repeating; o_tick every 4th cycle; o_busy=1.
//   Ratio 5 -> high 3 cycles, low 2 cycles; tick period 5; ratio 2 -> 1/1 toggle.
//   Ratio 6 -> 3 written mid-period -> current 6-cycle period completes (3H/3L), then 2H/1L.
//   en dropped at cycle 2 of ratio 8 -> period finishes (4H/4L), then IDLE with o_div_clk=0, o_busy=0.
//   Ratio 1 or 0 -> o_div_clk mirrors i_ref_clk, o_tick=1 every cycle; ratio -> 3 -> DIVIDING next edge.
//   N_CH=2 with ratios 3 and 7 concurrent, i_rst_n=0 mid-period -> both outputs 0 next edge; channels independent.

Source files
------------

// File: rtl/clk_div_multi.sv
// N-channel integer clock divider with per-channel runtime ratio.
// Ratio and enable are resampled only at period boundaries, so no runt pulses occur.
module clk_div_multi #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned DIV_W = 8
) (
  input  logic                  i_ref_clk,
  input  logic                  i_rst_n,
  input  logic [N_CH-1:0]       i_en,
  input  logic [N_CH*DIV_W-1:0] i_ratio,
  output logic [N_CH-1:0]       o_div_clk,
  output logic [N_CH-1:0]       o_tick,
  output logic [N_CH-1:0]       o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDING,
    BYPASS
  } state_t;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  state_t           state    [N_CH];
  logic [DIV_W-1:0] cnt      [N_CH];
  logic [DIV_W-1:0] r_act    [N_CH];
  logic [DIV_W-1:0] ratio    [N_CH];
  logic [DIV_W-1:0] cnt_inc  [N_CH];
  logic [DIV_W-1:0] high_len [N_CH];
  logic [N_CH-1:0]  ratio_ok;
  logic [N_CH-1:0]  div_reg;
  logic [N_CH-1:0]  tick_reg;

  always_comb begin
    ratio_ok = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      ratio[k]    = i_ratio[k*DIV_W +: DIV_W];
      ratio_ok[k] = (ratio[k] >= TWO);
      cnt_inc[k]  = cnt[k] + ONE;
      // Odd ratios put the extra cycle in the high phase.
      high_len[k] = (r_act[k] >> 1) + {{(DIV_W-1){1'b0}}, r_act[k][0]};
    end
  end

  always_ff @(posedge i_ref_clk) begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!i_rst_n) begin
        state[k]    <= IDLE;
        cnt[k]      <= '0;
        r_act[k]    <= '0;
        div_reg[k]  <= 1'b0;
        tick_reg[k] <= 1'b0;
      end else begin
        case (state[k])
          DIVIDING: begin
            if (cnt[k] != r_act[k] - ONE) begin
              cnt[k]      <= cnt_inc[k];
              div_reg[k]  <= (cnt_inc[k] < high_len[k]);
              tick_reg[k] <= 1'b0;
            end else if (!i_en[k]) begin
              state[k]    <= IDLE;
              div_reg[k]  <= 1'b0;
              tick_reg[k] <= 1'b0;
            end else if (ratio_ok[k]) begin
              cnt[k]      <= '0;
              r_act[k]    <= ratio[k];
              div_reg[k]  <= 1'b1;
              tick_reg[k] <= 1'b1;
            end else begin
              state[k]    <= BYPASS;
              div_reg[k]  <= 1'b0;
              tick_reg[k] <= 1'b1;
            end
          end
          default: begin
            // IDLE and BYPASS share entry decisions; only the idle-stay output differs.
            if (!i_en[k]) begin
              state[k]    <= IDLE;
              div_reg[k]  <= 1'b0;
              tick_reg[k] <= 1'b0;
            end else if (ratio_ok[k]) begin
              state[k]    <= DIVIDING;
              cnt[k]      <= '0;
              r_act[k]    <= ratio[k];
              div_reg[k]  <= 1'b1;
              tick_reg[k] <= 1'b1;
            end else begin
              state[k]    <= BYPASS;
              div_reg[k]  <= 1'b0;
              tick_reg[k] <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    o_div_clk = '0;
    o_busy    = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      o_div_clk[k] = (state[k] == BYPASS) ? i_ref_clk : div_reg[k];
      o_busy[k]    = (state[k] != IDLE);
    end
  end

  assign o_tick = tick_reg;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: ratio patterns, boundary-only changes, bypass, reset.
module tb_clk_div_multi;

  logic        clk;
  logic        rst_n;
  logic [1:0]  en;
  logic [15:0] ratio;
  logic [1:0]  div_clk;
  logic [1:0]  tick;
  logic [1:0]  busy;

  int n_chk  = 0;
  int n_fail = 0;

  clk_div_multi #(
    .N_CH  (2),
    .DIV_W (8)
  ) dut (
    .i_ref_clk (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_ratio   (ratio),
    .o_div_clk (div_clk),
    .o_tick    (tick),
    .o_busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ch(input string tag, input int ch, input logic d, input logic t, input logic b);
    check_eq({tag, "_div"},  32'(div_clk[ch]), 32'(d));
    check_eq({tag, "_tick"}, 32'(tick[ch]),    32'(t));
    check_eq({tag, "_busy"}, 32'(busy[ch]),    32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n full periods on a channel, h high cycles then l low cycles each.
  task automatic expect_periods(input string tag, input int ch, input int h, input int l, input int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < h + l; i++) begin
        step();
        chk_ch(tag, ch, (i < h), (i == 0), 1'b1);
      end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 2'b00;
    ratio = 16'h0000;
    step();
    step();
    chk_ch("rst0", 0, 1'b0, 1'b0, 1'b0);
    chk_ch("rst1", 1, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b1;
    step();
    chk_ch("idle0", 0, 1'b0, 1'b0, 1'b0);

    ratio[7:0] = 8'd4;
    en[0]      = 1'b1;
    expect_periods("r4", 0, 2, 2, 3);
    chk_ch("ch1_idle", 1, 1'b0, 1'b0, 1'b0);

    ratio[7:0] = 8'd5;
    expect_periods("r5", 0, 3, 2, 2);

    ratio[7:0] = 8'd2;
    expect_periods("r2", 0, 1, 1, 3);

    // Ratio change mid-period is deferred to the boundary.
    ratio[7:0] = 8'd6;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_ch("r6", 0, (i < 3), (i == 0), 1'b1);
      if (i == 1) ratio[7:0] = 8'd3;
    end
    expect_periods("r3_after6", 0, 2, 1, 2);

    // Enable drop mid-period: period still completes.
    ratio[7:0] = 8'd8;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_ch("r8", 0, (i < 4), (i == 0), 1'b1);
      if (i == 2) en[0] = 1'b0;
    end
    step();
    chk_ch("r8_idle", 0, 1'b0, 1'b0, 1'b0);
    step();
    chk_ch("r8_idle2", 0, 1'b0, 1'b0, 1'b0);

    // Bypass: divided clock mirrors the reference clock.
    ratio[7:0] = 8'd1;
    en[0]      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) ratio[7:0] = 8'd0;
      step();
      chk_ch("byp_hi", 0, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      chk_ch("byp_lo", 0, 1'b0, 1'b1, 1'b1);
    end
    step();
    ratio[7:0] = 8'd3;
    expect_periods("byp_to_r3", 0, 2, 1, 2);

    // Two channels concurrently, then reset mid-period.
    rst_n = 1'b0;
    step();
    ratio = {8'd7, 8'd3};
    en    = 2'b11;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_ch("dual_c0", 0, ((i % 3) < 2), ((i % 3) == 0), 1'b1);
      chk_ch("dual_c1", 1, ((i % 7) < 4), ((i % 7) == 0), 1'b1);
    end
    rst_n = 1'b0;
    step();
    chk_ch("midrst0", 0, 1'b0, 1'b0, 1'b0);
    chk_ch("midrst1", 1, 1'b0, 1'b0, 1'b0);

    // Maximum ratio: 128 high, 127 low.
    en          = 2'b10;
    ratio[15:8] = 8'd255;
    rst_n       = 1'b1;
    for (int i = 0; i < 255; i++) begin
      step();
      chk_ch("r255", 1, (i < 128), (i == 0), 1'b1);
    end
    chk_ch("r255_c0idle", 0, 1'b0, 1'b0, 1'b0);
    step();
    chk_ch("r255_wrap", 1, 1'b1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
